// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: streams round keys 0..10, one per clock.
// Optional round-key bank with indexed read port, enabled by AES_KEY_STORE_EN.
`timescale 1ns/1ps

module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  localparam logic [3:0] LAST_RND = 4'd10;

  // FIPS-197 S-box; entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    unique case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
          ^ {rc, 24'h000000};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t       state, state_next;
  logic [3:0]   cnt, cnt_next;
  logic [127:0] cur, cur_next;
  logic         done_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cur   <= cur_next;
      done  <= done_next;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cur_next   = cur;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        // The done cycle is IDLE too, but a start there is deliberately dropped.
        if (start && !done) begin
          cur_next   = key_in;
          cnt_next   = '0;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (cnt < LAST_RND) begin
          cur_next = next_key(cur, rcon(4'(cnt + 4'd1)));
          cnt_next = 4'(cnt + 4'd1);
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state == EXPAND);
  assign rk_valid = (state == EXPAND);
  assign rk_idx   = rk_valid ? cnt : 4'd0;
  assign rk_out   = rk_valid ? cur : '0;

`ifdef AES_KEY_STORE_EN
  logic [127:0] bank [0:10];

  // NOTE: the bank is a register file, so it is cleared on reset like any
  // other state; it must not be mapped onto reset-less RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) bank[i] <= '0;
    end else if (state == EXPAND) begin
      bank[cnt] <= cur;
    end
  end

  assign rd_key = (rd_idx <= LAST_RND) ? bank[rd_idx] : '0;
`else
  // Streaming-only build: no bank and no read port.
`endif

endmodule
